sar_conv_ctrl: RTL and testbench

- Initiator/reader for the SAR logic block's start/eoc/data interface.
- Paces conversions at a programmable sample period by holding the SAR parked in track mode (start high) and releasing it (start low) once per period.
- Captures the 8-bit result on eoc and presents it downstream on a valid/ready handshake.
- Also flags timeouts, late periods and overruns.

---
 rtl/sar_pkg.sv | 23 ++
 rtl/sar_period_timer.sv | 37 +++
 rtl/sar_conv_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sar_conv_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// sar_pkg: shared definitions for the SAR conversion controller.
//   SAR_DATA_W / SAR_PERIOD_W / SAR_MIN_PERIOD / SAR_TIMEOUT: parameter defaults
//   sar_state_e : controller state encoding
//   eff_period  : clamps a programmed sample period up to the minimum
package sar_pkg;

    localparam int unsigned SAR_DATA_W     = 8;
    localparam int unsigned SAR_PERIOD_W   = 16;
    localparam int unsigned SAR_MIN_PERIOD = 24;
    localparam int unsigned SAR_TIMEOUT    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        WAIT = 2'd2
    } sar_state_e;

    function automatic int unsigned eff_period(input int unsigned period,
                                               input int unsigned min_period);
        return (period < min_period) ? min_period : period;
    endfunction

endpackage

// File: rtl/sar_period_timer.sv
// sar_period_timer: launch-to-launch period counter.
//   clk, reset : clock, synchronous active-high reset
//   load       : restart the period at 0 and latch the clamped period
//   period     : programmed sample period, sampled only on load
//   expire     : high in the last cycle of the latched period
// The counter free-runs after expiry so a late conversion never stalls it.
module sar_period_timer
    import sar_pkg::*;
#(
    parameter int unsigned PERIOD_W   = SAR_PERIOD_W,
    parameter int unsigned MIN_PERIOD = SAR_MIN_PERIOD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [PERIOD_W-1:0] period,
    output logic                expire
);

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] per_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            per_q <= PERIOD_W'(MIN_PERIOD);
        end else if (load) begin
            cnt   <= '0;
            per_q <= PERIOD_W'(eff_period(32'(period), MIN_PERIOD));
        end else begin
            cnt   <= cnt + PERIOD_W'(1);
        end
    end

    assign expire = (cnt == per_q - PERIOD_W'(1));

endmodule

// File: rtl/sar_conv_ctrl.sv
// sar_conv_ctrl: paces SAR conversions, captures results, reports faults.
//   clk, reset      : clock, synchronous active-high reset
//   enable          : run conversions while high
//   sample_period   : cycles between launches (clamped up to MIN_PERIOD)
//   start           : to SAR, 1 = track, 0 = convert
//   eoc, data       : from SAR, one-cycle end-of-conversion with result
//   sample_data/valid/ready : single-entry result handshake
//   clr_status      : clears the sticky flags (a same-cycle set wins)
//   timeout_flag, late_flag, overrun_flag : sticky status
// Build option SAR_CTRL_AVG4_EN: publish the truncated mean of every four
// captured results instead of each result.
//
// state | meaning
// IDLE  | parked in track (start=1), waiting for enable
// CONV  | start=0, waiting for eoc or timeout
// WAIT  | start=1, waiting for the period to expire (or enable to drop)
module sar_conv_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned DATA_W     = SAR_DATA_W,
    parameter int unsigned PERIOD_W   = SAR_PERIOD_W,
    parameter int unsigned MIN_PERIOD = SAR_MIN_PERIOD,
    parameter int unsigned TIMEOUT    = SAR_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] sample_period,
    output logic                start,
    input  logic                eoc,
    input  logic [DATA_W-1:0]   data,
    output logic [DATA_W-1:0]   sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    input  logic                clr_status,
    output logic                timeout_flag,
    output logic                late_flag,
    output logic                overrun_flag
);

    localparam int unsigned       TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    sar_state_e        state, state_nxt;
    logic              launch;
    logic              expire;
    logic              tmo_hit;
    logic              capture;
    logic              set_timeout;
    logic              set_late;
    logic              set_overrun;
    logic              late_pend;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              push;
    logic [DATA_W-1:0] push_data;

    sar_period_timer #(
        .PERIOD_W   (PERIOD_W),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_period (
        .clk    (clk),
        .reset  (reset),
        .load   (launch),
        .period (sample_period),
        .expire (expire)
    );

    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    assign capture  = (state == CONV) && eoc;
    assign set_late = (state == CONV) && expire;

    always_comb begin
        state_nxt   = state;
        launch      = 1'b0;
        set_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = CONV;
                    launch    = 1'b1;
                end
            end
            CONV: begin
                if (eoc) begin
                    state_nxt = WAIT;
                end else if (tmo_hit) begin
                    state_nxt   = WAIT;
                    set_timeout = 1'b1;
                end
            end
            WAIT: begin
                // A period that ran out during CONV relaunches right away,
                // leaving exactly one start-high cycle.
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (expire || late_pend) begin
                    state_nxt = CONV;
                    launch    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            start     <= 1'b1;
            tmo_cnt   <= '0;
            late_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            start     <= (state_nxt != CONV);
            tmo_cnt   <= (state == CONV && state_nxt == CONV) ? tmo_cnt + TMO_W'(1) : '0;
            late_pend <= (launch || state == IDLE) ? 1'b0 : (late_pend || set_late);
        end
    end

`ifdef SAR_CTRL_AVG4_EN
    logic [DATA_W+1:0] acc;
    logic [DATA_W+1:0] acc_sum;
    logic [1:0]        acc_cnt;

    assign acc_sum   = acc + {2'b00, data};
    assign push      = capture && (acc_cnt == 2'd3);
    assign push_data = acc_sum[DATA_W+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            acc_cnt <= '0;
        end else if (capture) begin
            if (acc_cnt == 2'd3) begin
                acc     <= '0;
                acc_cnt <= '0;
            end else begin
                acc     <= acc_sum;
                acc_cnt <= acc_cnt + 2'd1;
            end
        end else if (set_timeout) begin
            acc     <= '0;
            acc_cnt <= '0;
        end
    end
`else
    assign push      = capture;
    assign push_data = data;
`endif

    // A result arriving while the register is full and not being drained is lost.
    assign set_overrun = push && sample_valid && !sample_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else if (push && (!sample_valid || sample_ready)) begin
            sample_data  <= push_data;
            sample_valid <= 1'b1;
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_flag <= 1'b0;
            late_flag    <= 1'b0;
            overrun_flag <= 1'b0;
        end else begin
            timeout_flag <= set_timeout || (timeout_flag && !clr_status);
            late_flag    <= set_late    || (late_flag    && !clr_status);
            overrun_flag <= set_overrun || (overrun_flag && !clr_status);
        end
    end

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// tb_sar_conv_ctrl: directed bench for sar_conv_ctrl with a behavioural SAR.
// Honours SAR_CTRL_AVG4_EN when the design is built with it.
module tb_sar_conv_ctrl;

    logic        clk = 1'b0;
    logic        reset, enable, start, eoc, sample_valid, sample_ready;
    logic        clr_status, timeout_flag, late_flag, overrun_flag;
    logic [15:0] sample_period;
    logic [7:0]  data, sample_data;

    always #5 clk = ~clk;

    sar_conv_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .sample_period (sample_period),
        .start         (start),
        .eoc           (eoc),
        .data          (data),
        .sample_data   (sample_data),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .clr_status    (clr_status),
        .timeout_flag  (timeout_flag),
        .late_flag     (late_flag),
        .overrun_flag  (overrun_flag)
    );

    int errs = 0;
    int nchk = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // SAR model: eoc sar_delay cycles after start falls (0 = never).
    int         sar_delay  = 18;
    int         sar_cnt    = 0;
    logic [7:0] sar_def    = 8'hA5;
    logic [7:0] data_q[$];
    logic       stray_req  = 1'b0;
    logic [7:0] stray_data = 8'hFF;

    initial begin
        eoc  = 1'b0;
        data = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            eoc = 1'b0;
            if (start !== 1'b0) begin
                sar_cnt = 0;
            end else begin
                sar_cnt++;
                if (sar_delay != 0 && sar_cnt == sar_delay) begin
                    eoc  = 1'b1;
                    data = (data_q.size() > 0) ? data_q.pop_front() : sar_def;
                end
            end
            if (stray_req) begin
                eoc  = 1'b1;
                data = stray_data;
            end
        end
    end

    // Monitor, sampled on the falling edge.
    int         cyc = 0, eoc_cnt = 0, lat_err = 0;
    int         conv_len = 0, hi_len = 0, last_fall = 0, last_rise = 0;
    logic       prev_start = 1'b1, exp_v = 1'b0;
    int         launch_q[$];
    logic [7:0] acc_q[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_v && !sample_valid) lat_err++;
            exp_v = eoc && !start;
            if (eoc && !start) eoc_cnt++;
            if (prev_start && !start) begin
                launch_q.push_back(cyc);
                hi_len    = cyc - last_rise;
                last_fall = cyc;
            end
            if (!prev_start && start) begin
                conv_len  = cyc - last_fall;
                last_rise = cyc;
            end
            if (sample_valid && sample_ready) acc_q.push_back(sample_data);
            prev_start = start;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_eoc(input int n);
        int tgt;
        int k;
        tgt = eoc_cnt + n;
        k   = 0;
        while (eoc_cnt < tgt && k < 200) begin
            nstep();
            k++;
        end
        check("eoc_wait", eoc_cnt, tgt);
    endtask

    task automatic idle_down();
        enable = 1'b0;
        repeat (40) nstep();
        check("idle_start", start, 1'b1);
        launch_q.delete();
        acc_q.delete();
    endtask

    task automatic clr_pulse();
        clr_status = 1'b1;
        nstep();
        clr_status = 1'b0;
        nstep();
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        sample_period = 16'd100;
        sample_ready  = 1'b1;
        clr_status    = 1'b0;
        repeat (3) nstep();
        check("rst_start", start, 1'b1);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_data", sample_data, 8'h00);
        check("rst_tmo", timeout_flag, 1'b0);
        check("rst_late", late_flag, 1'b0);
        check("rst_ovr", overrun_flag, 1'b0);
        reset = 1'b0;
        nstep();
        launch_q.delete();

`ifndef SAR_CTRL_AVG4_EN
        // Nominal pacing at 100 cycles, with a stray eoc during WAIT.
        sample_period = 16'd100;
        sar_delay     = 18;
        enable        = 1'b1;
        repeat (40) nstep();
        stray_req = 1'b1;
        nstep();
        stray_req = 1'b0;
        nstep();
        check("stray_valid", sample_valid, 1'b0);
        check("stray_data", sample_data, 8'hA5);
        repeat (270) nstep();
        check("nom_launches", launch_q.size(), 4);
        check("nom_int1", launch_q[1] - launch_q[0], 100);
        check("nom_int2", launch_q[2] - launch_q[1], 100);
        check("nom_conv_len", conv_len, 18);
        check("nom_samples", acc_q.size(), 3);
        check("nom_sample0", acc_q[0], 8'hA5);
        check("nom_latency", lat_err, 0);
        check("nom_tmo", timeout_flag, 1'b0);
        check("nom_late", late_flag, 1'b0);
        check("nom_ovr", overrun_flag, 1'b0);
        idle_down();
`endif

        // Period below minimum is clamped to 24.
        sample_period = 16'd5;
        sar_delay     = 18;
        enable        = 1'b1;
        repeat (80) nstep();
        check("clamp_int1", launch_q[1] - launch_q[0], 24);
        check("clamp_int2", launch_q[2] - launch_q[1], 24);
        check("clamp_late", late_flag, 1'b0);
        idle_down();

        // SAR never answers: 32-cycle timeout, launches stay on schedule.
        sample_period = 16'd100;
        sar_delay     = 0;
        enable        = 1'b1;
        repeat (210) nstep();
        check("tmo_conv_len", conv_len, 32);
        check("tmo_flag", timeout_flag, 1'b1);
        check("tmo_samples", acc_q.size(), 0);
        check("tmo_valid", sample_valid, 1'b0);
        check("tmo_int", launch_q[1] - launch_q[0], 100);
        check("tmo_late", late_flag, 1'b0);
        idle_down();
        clr_pulse();
        check("tmo_clr", timeout_flag, 1'b0);

        // Timeout outlasts a 24-cycle period: late, one start-high cycle.
        sample_period = 16'd5;
        sar_delay     = 0;
        enable        = 1'b1;
        repeat (80) nstep();
        check("late_int1", launch_q[1] - launch_q[0], 33);
        check("late_int2", launch_q[2] - launch_q[1], 33);
        check("late_flag", late_flag, 1'b1);
        check("late_hi_len", hi_len, 1);
        check("late_conv_len", conv_len, 32);
        idle_down();
        clr_pulse();
        check("late_clr", late_flag, 1'b0);
        check("late_tmo_clr", timeout_flag, 1'b0);

`ifndef SAR_CTRL_AVG4_EN
        // Overrun with ready low; clear and set on the same edge.
        sample_period = 16'd30;
        sar_delay     = 18;
        sample_ready  = 1'b0;
        data_q.push_back(8'h11);
        data_q.push_back(8'h22);
        data_q.push_back(8'h33);
        enable = 1'b1;
        wait_eoc(2);
        repeat (2) nstep();
        check("ovr_data", sample_data, 8'h11);
        check("ovr_valid", sample_valid, 1'b1);
        check("ovr_flag", overrun_flag, 1'b1);
        clr_pulse();
        check("ovr_clr", overrun_flag, 1'b0);
        wait_eoc(1);
        clr_pulse();
        check("ovr_set_wins", overrun_flag, 1'b1);
        check("ovr_data_hold", sample_data, 8'h11);
        sample_ready = 1'b1;
        nstep();
        check("ovr_drain", sample_valid, 1'b0);
        idle_down();
        clr_pulse();
`endif

        // Four results 10, 11, 12, 14.
        sample_period = 16'd24;
        sar_delay     = 18;
        sample_ready  = 1'b1;
        data_q.push_back(8'd10);
        data_q.push_back(8'd11);
        data_q.push_back(8'd12);
        data_q.push_back(8'd14);
        enable = 1'b1;
        wait_eoc(4);
        repeat (3) nstep();
`ifdef SAR_CTRL_AVG4_EN
        check("avg_count", acc_q.size(), 1);
        check("avg_value", acc_q[0], 8'd11);
`else
        check("seq_count", acc_q.size(), 4);
        check("seq_first", acc_q[0], 8'd10);
        check("seq_last", acc_q[3], 8'd14);
`endif
        idle_down();

        // Reset in the middle of a conversion.
        sample_ready = 1'b0;
        enable       = 1'b1;
        wait_eoc(1);
        repeat (10) nstep();
        check("pre_rst_conv", start, 1'b0);
`ifndef SAR_CTRL_AVG4_EN
        check("pre_rst_valid", sample_valid, 1'b1);
`endif
        reset = 1'b1;
        nstep();
        check("rst_mid_start", start, 1'b1);
        check("rst_mid_valid", sample_valid, 1'b0);
        check("rst_mid_data", sample_data, 8'h00);
        enable = 1'b0;
        reset  = 1'b0;
        repeat (3) nstep();
        check("post_rst_idle", start, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
